// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals for the shared memory port.
// The arbiter uses the slave modport. The environment uses the master modport.
interface mem_port_arbiter_if;
   logic        i_read;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_resp;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_byte_enable;
   logic [31:0] d_rdata;
   logic        d_resp;
   logic        pmem_read;
   logic        pmem_write;
   logic [31:0] pmem_address;
   logic [31:0] pmem_wdata;
   logic [3:0]  pmem_byte_enable;
   logic [31:0] pmem_rdata;
   logic        pmem_resp;

   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_byte_enable,
             pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable
   );

   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_byte_enable,
             pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-fetch and D-access requesters: D has fixed priority,
// and I is forced through after MAX_D_STREAK consecutive D grants while I waits.
module mem_port_arbiter #(
   parameter int MAX_D_STREAK = 4
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_streak;
   logic [3:0]  w_next_streak;
   logic        w_d_req;
   logic        w_grant_d;
   logic        w_grant_i;
   logic        w_mem_done;

   logic        r_read;
   logic        r_write;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_winner_d;
   logic [31:0] r_i_rdata;
   logic [31:0] r_d_rdata;

   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves one unassigned (no latch).
      w_next_state  = r_state;
      w_next_streak = r_streak;
      w_grant_d     = 1'b0;
      w_grant_i     = 1'b0;
      w_mem_done    = 1'b0;
      w_d_req       = bus.d_read | bus.d_write;
      unique case (r_state)
         IDLE: begin
            if (w_d_req && !(bus.i_read && r_streak == STREAK_MAX)) begin
               w_grant_d    = 1'b1;
               w_next_state = D_BUSY;
               if (!bus.i_read)
                  w_next_streak = 4'd0;
               else if (r_streak != STREAK_MAX)
                  w_next_streak = r_streak + 4'd1;
            end else if (bus.i_read) begin
               w_grant_i     = 1'b1;
               w_next_state  = I_BUSY;
               w_next_streak = 4'd0;
            end
         end
         I_BUSY, D_BUSY: begin
            if (bus.pmem_resp) begin
               w_mem_done   = 1'b1;
               w_next_state = DONE;
            end
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments; the async reset abandons any transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_streak <= 4'd0;
      end else begin
         r_state  <= w_next_state;
         r_streak <= w_next_streak;
      end
   end

   // Request register: the pmem bus is driven only from here, so it stays stable while BUSY.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_read     <= 1'b0;
         r_write    <= 1'b0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_be       <= 4'd0;
         r_winner_d <= 1'b0;
         r_i_rdata  <= 32'd0;
         r_d_rdata  <= 32'd0;
      end else if (w_grant_d) begin
         r_read     <= ~bus.d_write;
         r_write    <= bus.d_write;
         r_addr     <= bus.d_addr;
         r_wdata    <= bus.d_wdata;
         r_be       <= bus.d_byte_enable;
         r_winner_d <= 1'b1;
      end else if (w_grant_i) begin
         r_read     <= 1'b1;
         r_write    <= 1'b0;
         r_addr     <= bus.i_addr;
         r_wdata    <= 32'd0;
         r_be       <= 4'b1111;
         r_winner_d <= 1'b0;
      end else if (w_mem_done) begin
         r_read  <= 1'b0;
         r_write <= 1'b0;
         if (r_state == I_BUSY)
            r_i_rdata <= bus.pmem_rdata;
         else if (r_read)
            r_d_rdata <= bus.pmem_rdata;
      end
   end

   assign bus.pmem_read        = r_read;
   assign bus.pmem_write       = r_write;
   assign bus.pmem_address     = r_addr;
   assign bus.pmem_wdata       = r_wdata;
   assign bus.pmem_byte_enable = r_be;
   assign bus.i_rdata          = r_i_rdata;
   assign bus.d_rdata          = r_d_rdata;
   assign bus.i_resp           = (r_state == DONE) && !r_winner_d;
   assign bus.d_resp           = (r_state == DONE) &&  r_winner_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: per-side expected transactions plus an expected
// service order, with a wait-state memory model answering the pmem strobes.
module tb_mem_port_arbiter;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      int          strobe_len;
   } txn_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   int   mem_wait;

   txn_t        i_q[$];
   txn_t        d_q[$];
   bit          order_q[$];
   logic [31:0] exp_d_last;

   mem_port_arbiter_if ifc();

   mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h40) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   // Memory: answers mem_wait cycles after the strobe appears, for one cycle.
   initial begin
      int cnt;
      cnt = 0;
      ifc.pmem_resp  = 1'b0;
      ifc.pmem_rdata = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            ifc.pmem_resp = 1'b0;
            cnt = 0;
         end else if (ifc.pmem_resp) begin
            ifc.pmem_resp = 1'b0;
         end else if (ifc.pmem_read || ifc.pmem_write) begin
            if (cnt >= mem_wait) begin
               ifc.pmem_resp  = 1'b1;
               ifc.pmem_rdata = ifc.pmem_read ? mem_word(ifc.pmem_address) : 32'hBAD0_0BAD;
               cnt = 0;
            end else begin
               cnt++;
            end
         end
      end
   end

   // Monitor: captures the pmem request at strobe start and scores it at the resp pulse.
   initial begin
      bit          busy_seen;
      bit          prev_resp;
      bit          addr_moved;
      bit          side_d;
      int          strobe_cnt;
      logic        cap_wr;
      logic [31:0] cap_addr;
      logic [31:0] cap_wdata;
      logic [3:0]  cap_be;
      txn_t        t;
      busy_seen = 0; prev_resp = 0; addr_moved = 0; strobe_cnt = 0;
      cap_wr = 0; cap_addr = 0; cap_wdata = 0; cap_be = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_seen = 0;
            prev_resp = 0;
         end else begin
            if (prev_resp) check("resp_one_cycle", {31'd0, ifc.i_resp | ifc.d_resp}, 32'd0);
            if (ifc.pmem_read || ifc.pmem_write) begin
               if (!busy_seen) begin
                  busy_seen  = 1;
                  strobe_cnt = 1;
                  addr_moved = 0;
                  cap_wr     = ifc.pmem_write;
                  cap_addr   = ifc.pmem_address;
                  cap_wdata  = ifc.pmem_wdata;
                  cap_be     = ifc.pmem_byte_enable;
               end else begin
                  strobe_cnt++;
                  if (ifc.pmem_address !== cap_addr || ifc.pmem_write !== cap_wr) addr_moved = 1;
               end
            end
            if (ifc.i_resp || ifc.d_resp) begin
               check("resp_exclusive", {31'd0, ifc.i_resp & ifc.d_resp}, 32'd0);
               if (order_q.size() == 0) begin
                  check("unexpected_resp", {31'd0, ifc.d_resp}, {31'd0, ifc.i_resp});
                  check("unexpected_resp", 32'd1, 32'd0);
               end else begin
                  side_d = order_q.pop_front();
                  check("service_order", {31'd0, ifc.d_resp}, {31'd0, side_d});
                  if (ifc.d_resp && d_q.size() > 0) begin
                     t = d_q.pop_front();
                     check("d_op_write", {31'd0, cap_wr}, {31'd0, t.wr});
                     check("d_addr", cap_addr, t.addr);
                     check("d_be", {28'd0, cap_be}, {28'd0, t.be});
                     if (t.wr) begin
                        check("d_wdata", cap_wdata, t.wdata);
                        check("d_rdata_kept", ifc.d_rdata, exp_d_last);
                     end else begin
                        check("d_rdata", ifc.d_rdata, t.rdata);
                        exp_d_last = t.rdata;
                     end
                     check("d_strobe_len", strobe_cnt, t.strobe_len);
                     check("d_bus_stable", {31'd0, addr_moved}, 32'd0);
                  end else if (ifc.i_resp && i_q.size() > 0) begin
                     t = i_q.pop_front();
                     check("i_op_write", {31'd0, cap_wr}, 32'd0);
                     check("i_addr", cap_addr, t.addr);
                     check("i_be", {28'd0, cap_be}, 32'hF);
                     check("i_rdata", ifc.i_rdata, t.rdata);
                     check("i_strobe_len", strobe_cnt, t.strobe_len);
                     check("i_bus_stable", {31'd0, addr_moved}, 32'd0);
                  end
               end
               busy_seen = 0;
            end
            prev_resp = ifc.i_resp | ifc.d_resp;
         end
      end
   end

   task automatic wait_resp(input bit side_d);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(side_d ? ifc.d_resp : ifc.i_resp) && n < 100);
      if (n >= 100) check(side_d ? "d_resp_timeout" : "i_resp_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_i(input logic [31:0] addr);
      txn_t t;
      t = '{wr: 1'b0, addr: addr, wdata: 32'd0, be: 4'hF, rdata: mem_word(addr),
            strobe_len: mem_wait + 1};
      i_q.push_back(t);
      ifc.i_read = 1'b1;
      ifc.i_addr = addr;
      wait_resp(1'b0);
      ifc.i_read = 1'b0;
   endtask

   task automatic run_d(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      txn_t t;
      t = '{wr: wr, addr: addr, wdata: wdata, be: be, rdata: mem_word(addr),
            strobe_len: mem_wait + 1};
      d_q.push_back(t);
      ifc.d_read        = rd;
      ifc.d_write       = wr;
      ifc.d_addr        = addr;
      ifc.d_wdata       = wdata;
      ifc.d_byte_enable = be;
      wait_resp(1'b1);
      ifc.d_read  = 1'b0;
      ifc.d_write = 1'b0;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_pmem_read"},  {31'd0, ifc.pmem_read},  32'd0);
      check({pfx, "_pmem_write"}, {31'd0, ifc.pmem_write}, 32'd0);
      check({pfx, "_pmem_addr"},  ifc.pmem_address,        32'd0);
      check({pfx, "_pmem_wdata"}, ifc.pmem_wdata,          32'd0);
      check({pfx, "_pmem_be"},    {28'd0, ifc.pmem_byte_enable}, 32'd0);
      check({pfx, "_i_resp"},     {31'd0, ifc.i_resp},     32'd0);
      check({pfx, "_d_resp"},     {31'd0, ifc.d_resp},     32'd0);
      check({pfx, "_i_rdata"},    ifc.i_rdata,             32'd0);
      check({pfx, "_d_rdata"},    ifc.d_rdata,             32'd0);
   endtask

   initial begin
      int n;
      n_checks = 0; n_pass = 0; mem_wait = 0; exp_d_last = 32'd0;
      rst = 1'b0;
      ifc.i_read = 0; ifc.i_addr = 0;
      ifc.d_read = 0; ifc.d_write = 0; ifc.d_addr = 0; ifc.d_wdata = 0; ifc.d_byte_enable = 0;

      // Asynchronous reset asserted mid-cycle, then idle with no requests.
      #12 rst = 1'b1;
      #1 check_reset_outputs("rst0");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("idle_no_strobe", {31'd0, ifc.pmem_read | ifc.pmem_write}, 32'd0);
      end

      // Single I read with two memory wait cycles.
      mem_wait = 2;
      order_q.push_back(1'b0);
      run_i(32'h0000_0040);
      @(negedge clk);

      // D read, zero-wait memory, partial byte enables.
      mem_wait = 0;
      order_q.push_back(1'b1);
      run_d(1'b1, 1'b0, 32'h0000_0180, 32'h0, 4'b0101);
      @(negedge clk);

      // Simultaneous I read and D write: D first, d_rdata retained across the write.
      mem_wait = 1;
      order_q.push_back(1'b1);
      order_q.push_back(1'b0);
      fork
         run_d(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011);
         run_i(32'h0000_0080);
      join
      @(negedge clk);

      // Read and write together count as a write.
      mem_wait = 0;
      order_q.push_back(1'b1);
      run_d(1'b1, 1'b1, 32'h0000_0240, 32'hCAFE_F00D, 4'b1100);
      @(negedge clk);

      // Starvation guard: I held, D re-requests back to back.
      mem_wait = 1;
      order_q.push_back(1'b1); order_q.push_back(1'b1); order_q.push_back(1'b1);
      order_q.push_back(1'b1); order_q.push_back(1'b0); order_q.push_back(1'b1);
      fork
         run_i(32'h0000_0400);
         for (int k = 0; k < 5; k++)
            run_d(1'b1, 1'b0, 32'h0000_0500 + 32'(k * 4), 32'h0, 4'hF);
      join
      @(negedge clk);

      // Requester address changes during BUSY; the pmem address must not follow.
      mem_wait = 3;
      order_q.push_back(1'b1);
      fork
         run_d(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
         begin
            repeat (2) @(negedge clk);
            ifc.d_addr = 32'h0000_0300;
         end
      join
      @(negedge clk);

      // Reset during D_BUSY: strobes drop at once, no d_resp afterwards.
      mem_wait = 5;
      ifc.d_read = 1'b1; ifc.d_addr = 32'h0000_0600; ifc.d_byte_enable = 4'hF;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ifc.pmem_read && n < 20);
      check("busy_before_rst", {31'd0, ifc.pmem_read}, 32'd1);
      #3 rst = 1'b1;
      ifc.d_read = 1'b0;
      #1 check_reset_outputs("rst_mid");
      exp_d_last = 32'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // After release, a lone I read is served normally.
      mem_wait = 0;
      order_q.push_back(1'b0);
      run_i(32'h0000_0040);
      repeat (3) @(negedge clk);

      check("order_drained", order_q.size(), 32'd0);
      check("d_queue_drained", d_q.size(), 32'd0);
      check("i_queue_drained", i_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
